nibble_serial_adder_ctrl: RTL and testbench

//   Multi-cycle sequencer for wide additions: WIDTH+WIDTH+cin over WIDTH/4 clock cycles,
//   one nibble per cycle, through the existing 4-bit Ripple_Carry_Adder instantiated alongside it.

---
 rtl/nibble_serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer that performs a WIDTH-bit add one nibble per clock through an external
// 4-bit ripple-carry adder, carrying between nibbles through a register.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int NNIB  = WIDTH / 4;
  localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is a request sampled only in IDLE or DONE; done is a one-cycle
  // valid pulse, and sum_out/cout_out stay valid until the next operation completes.
  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  // Accumulator with the adder's current nibble merged in at position idx.
  always_comb begin
    acc_d = acc_q;
    for (int n = 0; n < NNIB; n++) begin
      if (idx_q == IDX_W'(n)) begin
        acc_d[4*n +: 4] = add_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= cin_in;
            idx_q   <= '0;
            acc_q   <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          carry_q <= add_cout;
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            idx_q   <= '0;
            sum_q   <= acc_d;
            cout_q  <= add_cout;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Adder is driven only from registers, so no input port reaches add_* combinationally.
  assign add_a    = a_q[3:0];
  assign add_b    = b_q[3:0];
  assign add_cin  = carry_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sum_q;
  assign cout_out = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl with a behavioural 4-bit adder standing in for
// Ripple_Carry_Adder; results are checked against plain wide arithmetic.
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;
  localparam int NNIB  = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic [4:0]       add_res;

  int errors = 0;
  int checks = 0;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] last_res;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  assign add_res  = 5'(add_a) + 5'(add_b) + 5'(add_cin);
  assign add_sum  = add_res[3:0];
  assign add_cout = add_res[4];

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if ({cout_out, sum_out} !== 17'h0) begin errors++; $display("FAIL reset_result got %h exp 0", {cout_out, sum_out}); end
    checks++; if ({add_a, add_b, add_cin} !== 9'h0) begin errors++; $display("FAIL reset_adder_drive got %h exp 0", {add_a, add_b, add_cin}); end
    last_res = '0;
  endtask

  // One operation from IDLE; poke >= 0 pulses start with junk operands at that RUN cycle.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input int poke, input string name);
    int cyc;
    int unsigned mask, ps;
    logic [3:0] ea, eb;
    logic ec;
    logic [WIDTH:0] exp_v, got_v;
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    exp_q.push_back((WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(c));
    tick();
    start = 1'b0;
    a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); cin_in = 1'($urandom);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (cyc < NNIB) begin
        mask = (32'd1 << (4*cyc)) - 32'd1;
        ps   = (32'(a) & mask) + (32'(b) & mask) + 32'(c);
        ec   = 1'((ps >> (4*cyc)) & 32'd1);
        ea   = 4'((32'(a) >> (4*cyc)) & 32'hF);
        eb   = 4'((32'(b) >> (4*cyc)) & 32'hF);
        checks++; if ({add_a, add_b, add_cin} !== {ea, eb, ec}) begin errors++; $display("FAIL %s drive_nib%0d got %h exp %h", name, cyc, {add_a, add_b, add_cin}, {ea, eb, ec}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_run%0d got %b exp 1", name, cyc, busy); end
      end
      checks++; if ({cout_out, sum_out} !== last_res) begin errors++; $display("FAIL %s result_held got %h exp %h", name, {cout_out, sum_out}, last_res); end
      if (cyc == poke) begin
        start = 1'b1; a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); cin_in = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    checks++; if (cyc !== NNIB) begin errors++; $display("FAIL %s done_latency got %0d exp %0d", name, cyc, NNIB); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b exp 0", name, busy); end
    exp_v = exp_q.pop_front();
    got_v = {cout_out, sum_out};
    checks++; if (got_v !== exp_v) begin errors++; $display("FAIL %s result got %h exp %h", name, got_v, exp_v); end
    last_res = exp_v;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse_width got %b exp 0", name, done); end
  endtask

  task automatic test_basic();
    run_op(16'h1234, 16'h4321, 1'b0, -1, "basic");
  endtask

  task automatic test_carry_ripple();
    run_op(16'hFFFF, 16'h0001, 1'b0, -1, "ripple_b1");
    run_op(16'hFFFF, 16'h0000, 1'b1, -1, "ripple_cin");
    run_op(16'h8000, 16'h8000, 1'b0, -1, "msb_carry");
  endtask

  task automatic test_start_during_run();
    run_op(16'h0F0F, 16'h7070, 1'b1, 1, "start_in_run");
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_run no_restart got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    a_in = 16'hABCD; b_in = 16'h1111; cin_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_mid busy_done got %b exp 00", {busy, done}); end
    checks++; if ({cout_out, sum_out} !== 17'h0) begin errors++; $display("FAIL rst_mid result got %h exp 0", {cout_out, sum_out}); end
    checks++; if ({add_a, add_b, add_cin} !== 9'h0) begin errors++; $display("FAIL rst_mid adder_drive got %h exp 0", {add_a, add_b, add_cin}); end
    last_res = '0;
    for (int i = 0; i < NNIB + 2; i++) begin
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid stray_done got %b exp 0", done); end
    end
    run_op(16'h00FF, 16'h0001, 1'b0, -1, "after_rst");
  endtask

  task automatic test_back_to_back();
    int cnt, n_done, guard;
    logic [WIDTH:0] exp_v;
    a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); cin_in = 1'($urandom); start = 1'b1;
    exp_q.push_back((WIDTH+1)'(a_in) + (WIDTH+1)'(b_in) + (WIDTH+1)'(cin_in));
    tick();
    cnt = 0; n_done = 0; guard = 0;
    while (n_done < 8 && guard < 200) begin
      a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); cin_in = 1'($urandom);
      tick();
      cnt++; guard++;
      if (done === 1'b1) begin
        checks++; if (cnt !== NNIB) begin errors++; $display("FAIL b2b interval got %0d exp %0d", cnt + 1, NNIB + 1); end
        exp_v = exp_q.pop_front();
        checks++; if ({cout_out, sum_out} !== exp_v) begin errors++; $display("FAIL b2b result%0d got %h exp %h", n_done, {cout_out, sum_out}, exp_v); end
        last_res = exp_v;
        n_done++;
        cnt = -1;
        if (n_done < 8) begin
          a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); cin_in = 1'($urandom);
          exp_q.push_back((WIDTH+1)'(a_in) + (WIDTH+1)'(b_in) + (WIDTH+1)'(cin_in));
          tick();
          cnt = 0;
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b reaccept got %b exp 1", busy); end
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++; if (n_done !== 8) begin errors++; $display("FAIL b2b timeout got %0d ops exp 8", n_done); end
    tick(); tick();
    exp_q.delete();
  endtask

  task automatic test_random();
    int gap;
    for (int i = 0; i < 200; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), -1, "random");
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ripple();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
